// File: rtl/isr_square.sv
// Purpose     : iterative unsigned squarer (root -> root*root), STEP multiplier bits per cycle.
// Latency     : done rises WIDTH/STEP clock edges after the edge that accepts start.
// Backpressure: none; start is accepted only in IDLE/DONE, ignored while busy (no queueing).
//
// Ports:
//   clock  - system clock, all state on posedge
//   reset  - asynchronous active-low reset
//   start  - request pulse, accepted when not busy
//   root   - WIDTH-bit unsigned operand, latched on an accepted start
//   square - 2*WIDTH-bit result, meaningful only while done=1
//   done   - registered result-valid flag, held until the next accepted start
//   busy   - registered computation-in-progress flag
// Optional (macro ISR_SQUARE_CHECK_EN):
//   target - 2*WIDTH-bit compare value, latched with root
//   match  - registered square == target, valid with done
//   over   - registered square >  target, valid with done
module isr_square #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     root,
`ifdef ISR_SQUARE_CHECK_EN
  input  logic [2*WIDTH-1:0]   target,
  output logic                 match,
  output logic                 over,
`endif
  output logic [2*WIDTH-1:0]   square,
  output logic                 done,
  output logic                 busy
);

  localparam int ITER = WIDTH / STEP;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  // A partial final digit would silently drop multiplier bits, so refuse to build.
  generate
    if ((WIDTH % STEP) != 0) begin : g_bad_step
      $error("isr_square: STEP must divide WIDTH evenly");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q,  state_d;
  logic [WIDTH-1:0]     mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic [2*WIDTH-1:0]   square_q, square_d;
  logic                 done_q,   done_d;
  logic                 busy_q,   busy_d;
`ifdef ISR_SQUARE_CHECK_EN
  logic [2*WIDTH-1:0]   target_q, target_d;
  logic                 match_q,  match_d;
  logic                 over_q,   over_d;
`endif

  // One radix-2^STEP digit of the multiplier times the multiplicand, placed at
  // the digit's weight. The running sum never exceeds root^2, so no overflow.
  logic [31:0]          shamt;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   acc_sum;

  assign shamt   = 32'(cnt_q) * 32'(STEP);
  assign partial = ((2*WIDTH)'(mcand_q) * (2*WIDTH)'(mplier_q[STEP-1:0])) << shamt;
  assign acc_sum = acc_q + partial;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    square_d = square_q;
    done_d   = done_q;
    busy_d   = busy_q;
`ifdef ISR_SQUARE_CHECK_EN
    target_d = target_q;
    match_d  = match_q;
    over_d   = over_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_BUSY;
          mcand_d  = root;
          mplier_d = root;
          acc_d    = '0;
          cnt_d    = '0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
`ifdef ISR_SQUARE_CHECK_EN
          target_d = target;
          match_d  = 1'b0;
          over_d   = 1'b0;
`endif
        end
      end
      S_BUSY: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          square_d = acc_sum;
          done_d   = 1'b1;
          busy_d   = 1'b0;
`ifdef ISR_SQUARE_CHECK_EN
          match_d  = (acc_sum == target_q);
          over_d   = (acc_sum >  target_q);
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      square_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ISR_SQUARE_CHECK_EN
      target_q <= '0;
      match_q  <= 1'b0;
      over_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      square_q <= square_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef ISR_SQUARE_CHECK_EN
      target_q <= target_d;
      match_q  <= match_d;
      over_q   <= over_d;
`endif
    end
  end

  assign square = square_q;
  assign done   = done_q;
  assign busy   = busy_q;
`ifdef ISR_SQUARE_CHECK_EN
  assign match  = match_q;
  assign over   = over_q;
`endif

endmodule

// File: doc/isr_square.md
Name: isr_square

Overview:
- Iterative unsigned integer squarer: the inverse of the integer square root unit.
- Takes a 32-bit root and produces its 64-bit square through a shift-add datapath, with a start/done handshake.
- Used beside the ISR to check root results (root^2 <= value < (root+1)^2) and as a reusable multi-cycle squaring block.

Parameters:
- WIDTH, 32, operand width in bits; square is 2*WIDTH bits.
- STEP, 4, multiplier bits consumed per cycle; must divide WIDTH evenly (elaboration error otherwise).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request pulse; sampled at posedge.
- root  input  WIDTH  unsigned operand; sampled only on an accepted start.
- square  output  2*WIDTH  unsigned result; valid while done=1.
- done  output  1  result valid, registered.
- busy  output  1  computation in progress, registered.

Behaviour:
- Reset (reset=0, async): state=IDLE, square=0, done=0, busy=0, internal counter and operand registers cleared. Outputs change immediately, without waiting for a clock edge.
- FSM states: IDLE, BUSY, DONE.
- Start acceptance: start=1 at posedge while in IDLE or DONE is accepted.
  - root is latched as both multiplicand and multiplier.
  - Accumulator and counter are cleared.
  - State goes to BUSY; busy=1, done=0.
- BUSY, each posedge:
  - Add (multiplicand * low STEP bits of the multiplier) << (counter*STEP) into a 2*WIDTH accumulator; no overflow is possible.
  - Shift the multiplier right by STEP; counter+1.
  - After the WIDTH/STEP-th iteration: square=accumulator, state=DONE, done=1, busy=0.
- Latency: done rises exactly WIDTH/STEP posedges after the accepting edge (8 with defaults).
- start while BUSY is ignored; no queueing. root changes during BUSY have no effect.
- DONE:
  - square and done hold indefinitely until the next accepted start.
  - An accepted start in DONE drops done on that same edge (back-to-back operation, no idle cycle required).
- square is not defined as valid while done=0. The RTL holds its previous value, and the bench must not check it then.
- Reset mid-operation aborts the operation with no output pulse. The first start after reset deasserts begins a fresh computation.
- Edge values:
  - root=0 gives 0.
  - root=2^WIDTH-1 gives 2^(2*WIDTH) - 2^(WIDTH+1) + 1.

Optional Feature:
- Macro: ISR_SQUARE_CHECK_EN.
- When defined, these ports are added:
  - target  input  2*WIDTH: latched with root on an accepted start.
  - match  output  1: registered flag, square==target.
  - over  output  1: registered flag, square>target.
- match and over update on the same edge done rises, and hold with square.
- match and over reset to 0 and are 0 whenever done=0.
- ISR check usage: result r is correct iff, for r, over=0, and, for r+1, over=1.
- When not defined: no target/match/over ports, no comparator logic; all other behaviour is identical.

Test Plan:
- Reset held 4 cycles, release, start with root=5 -> done=1 exactly 8 posedges later, square=25, busy low on the same edge.
- root=0xFFFFFFFF -> square=0xFFFFFFFE00000001; root=0 -> square=0; root=0x10000 -> square=0x100000000.
- Start root=7, then at cycles 2-4 of BUSY pulse start with root=9 -> pulses ignored, square=49 at cycle 8.
- Reset driven low at cycle 3 of BUSY (between clock edges) -> done/busy/square go to 0 immediately; next start root=3 -> square=9 after 8 cycles.
- Back-to-back: start root=12 in DONE from the prior op -> done low on that edge, square=144 after 8 cycles; 1000 random roots checked against a reference squarer.
- With ISR_SQUARE_CHECK_EN:
  - root=5, target=24 -> match=0, over=1.
  - target=25 -> match=1, over=0.
  - root=4, target=24 -> match=0, over=0.
